// File: rtl/rggen_axi4lite_bridge_if.sv
// AXI4-Lite channel bundle shared by the register-block bridge
// and whatever master drives it.
interface rggen_axi4lite_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDRESS_WIDTH-1:0]  awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDRESS_WIDTH-1:0]  araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport slave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr, arprot,
    input  rready,
    output awready, wready,
    output bvalid, bresp,
    output arready,
    output rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr, arprot,
    output rready,
    input  awready, wready,
    input  bvalid, bresp,
    input  arready,
    input  rvalid, rdata, rresp
  );
endinterface

// File: rtl/rggen_axi4lite_bridge.sv
// AXI4-Lite slave front end: single-entry AW/W/AR hold buffers,
// arbitration, range decode and a single-outstanding local bus.
module rggen_axi4lite_bridge #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS = '0,
  parameter int SIZE           = 256,
  parameter int ARBITRATION    = 0,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int LOCAL_AW = $clog2(SIZE),
  localparam int STRB_W   = DATA_WIDTH / 8
) (
  input  logic                clk,
  input  logic                rst_n,
  rggen_axi4lite_if.slave     axi4lite_if,
  output logic                reg_valid,
  output logic                reg_write,
  output logic [LOCAL_AW-1:0] reg_address,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic [STRB_W-1:0]   reg_wstrb,
  input  logic                reg_ready,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                reg_error
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ?
    $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [LOCAL_AW-1:0] AMASK =
    ~LOCAL_AW'(STRB_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPONSE
  } state_e;

  state_e state_q, state_d;

  logic                     aw_full_q, aw_full_d;
  logic [ADDRESS_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic                     w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0]    w_data_q, w_data_d;
  logic [STRB_W-1:0]        w_strb_q, w_strb_d;
  logic                     ar_full_q, ar_full_d;
  logic [ADDRESS_WIDTH-1:0] ar_addr_q, ar_addr_d;

  logic awready_q, wready_q, arready_q;

  logic                  write_q, write_d;
  logic [LOCAL_AW-1:0]   addr_q, addr_d;
  logic [1:0]            resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rr_q, rr_d;
  logic [TW-1:0]         timer_q, timer_d;

  logic                     wr_cand;
  logic                     rd_cand;
  logic                     grant_wr;
  logic [ADDRESS_WIDTH-1:0] gaddr;
  logic                     hit;
  logic                     b_hs;
  logic                     r_hs;
  logic                     unused_prot;

  assign unused_prot = ^{axi4lite_if.awprot,
                         axi4lite_if.arprot};

  assign wr_cand = aw_full_q && w_full_q;
  assign rd_cand = ar_full_q;

  // rr_q set means the read side owns priority next time
  always_comb begin
    grant_wr = wr_cand;
    if (ARBITRATION == 1) begin
      grant_wr = wr_cand && !rd_cand;
    end else if (ARBITRATION == 2) begin
      grant_wr = wr_cand && (!rd_cand || !rr_q);
    end
  end

  assign gaddr = grant_wr ? aw_addr_q : ar_addr_q;
  assign hit   = (gaddr >> LOCAL_AW) ==
                 (BASE_ADDRESS >> LOCAL_AW);

  assign b_hs = (state_q == RESPONSE) && write_q &&
                axi4lite_if.bready;
  assign r_hs = (state_q == RESPONSE) && !write_q &&
                axi4lite_if.rready;

  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    ar_full_d = ar_full_q;
    ar_addr_d = ar_addr_q;
    if (b_hs) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
    if (r_hs) begin
      ar_full_d = 1'b0;
    end
    if (axi4lite_if.awvalid && awready_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = axi4lite_if.awaddr;
    end
    if (axi4lite_if.wvalid && wready_q) begin
      w_full_d = 1'b1;
      w_data_d = axi4lite_if.wdata;
      w_strb_d = axi4lite_if.wstrb;
    end
    if (axi4lite_if.arvalid && arready_q) begin
      ar_full_d = 1'b1;
      ar_addr_d = axi4lite_if.araddr;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    resp_d  = resp_q;
    rdata_d = rdata_q;
    rr_d    = rr_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (wr_cand || rd_cand) begin
          write_d = grant_wr;
          addr_d  = gaddr[LOCAL_AW-1:0] & AMASK;
          rr_d    = grant_wr;
          timer_d = '0;
          if (hit) begin
            state_d = ACCESS;
          end else begin
            state_d = RESPONSE;
            resp_d  = 2'b11;
            rdata_d = '0;
          end
        end
      end
      ACCESS: begin
        if (reg_ready) begin
          state_d = RESPONSE;
          resp_d  = reg_error ? 2'b10 : 2'b00;
          rdata_d = write_q ? '0 : reg_rdata;
        end else if ((TIMEOUT_CYCLES > 0) &&
                     (timer_q == TLAST)) begin
          state_d = RESPONSE;
          resp_d  = 2'b10;
          rdata_d = '0;
        end else if (TIMEOUT_CYCLES > 0) begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESPONSE: begin
        if (b_hs || r_hs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_full_q <= 1'b0;
      ar_addr_q <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      resp_q    <= 2'b00;
      rdata_q   <= '0;
      rr_q      <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      ar_full_q <= ar_full_d;
      ar_addr_q <= ar_addr_d;
      awready_q <= !aw_full_d;
      wready_q  <= !w_full_d;
      arready_q <= !ar_full_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      rr_q      <= rr_d;
      timer_q   <= timer_d;
    end
  end

  assign reg_valid   = (state_q == ACCESS);
  assign reg_write   = write_q;
  assign reg_address = addr_q;
  assign reg_wdata   = write_q ? w_data_q : '0;
  assign reg_wstrb   = write_q ? w_strb_q : '0;

  assign axi4lite_if.awready = awready_q;
  assign axi4lite_if.wready  = wready_q;
  assign axi4lite_if.arready = arready_q;
  assign axi4lite_if.bvalid  = (state_q == RESPONSE) && write_q;
  assign axi4lite_if.bresp   = resp_q;
  assign axi4lite_if.rvalid  = (state_q == RESPONSE) && !write_q;
  assign axi4lite_if.rresp   = resp_q;
  assign axi4lite_if.rdata   = rdata_q;

endmodule

// File: tb/tb_rggen_axi4lite_bridge.sv
// Bench for the AXI4-Lite register bridge: queued expectations
// checked by a monitor on reg-bus and response handshakes.
module tb_rggen_axi4lite_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rggen_axi4lite_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) bus ();
  rggen_axi4lite_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) bus2 ();

  logic        reg_valid;
  logic        reg_write;
  logic [7:0]  reg_address;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_ready;
  logic [31:0] reg_rdata;
  logic        reg_error;

  logic        reg_valid_b;
  logic        reg_write_b;
  logic [7:0]  reg_address_b;
  logic [31:0] unused_wdata_b;
  logic [3:0]  unused_wstrb_b;

  rggen_axi4lite_bridge #(
    .ADDRESS_WIDTH(16), .DATA_WIDTH(32),
    .BASE_ADDRESS(16'h0000), .SIZE(256),
    .ARBITRATION(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .axi4lite_if(bus),
    .reg_valid(reg_valid), .reg_write(reg_write),
    .reg_address(reg_address), .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb), .reg_ready(reg_ready),
    .reg_rdata(reg_rdata), .reg_error(reg_error)
  );

  rggen_axi4lite_bridge #(
    .ADDRESS_WIDTH(16), .DATA_WIDTH(32),
    .BASE_ADDRESS(16'h0000), .SIZE(256),
    .ARBITRATION(1), .TIMEOUT_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .axi4lite_if(bus2),
    .reg_valid(reg_valid_b), .reg_write(reg_write_b),
    .reg_address(reg_address_b), .reg_wdata(unused_wdata_b),
    .reg_wstrb(unused_wstrb_b), .reg_ready(reg_valid_b),
    .reg_rdata(32'h0), .reg_error(1'b0)
  );

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } reg_exp_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_exp_t;

  reg_exp_t reg_q[$];
  rsp_exp_t rsp_q[$];

  int checks = 0;
  int errors = 0;
  int vcyc = 0;
  int racc = 0;

  logic rsp_en = 1'b1;
  int   rsp_delay = 1;

  // register block model: read data is a fixed tag plus offset
  assign reg_rdata = 32'hC0DE_0000 | {24'h0, reg_address};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got no event expected one within bound", nm);
  endtask

  task automatic push_reg(input logic wr, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    reg_exp_t e;
    e.wr = wr; e.addr = a; e.wdata = d; e.strb = s;
    reg_q.push_back(e);
  endtask

  task automatic push_rsp(input logic wr, input logic [1:0] r,
                          input logic [31:0] d);
    rsp_exp_t e;
    e.wr = wr; e.resp = r; e.data = d;
    rsp_q.push_back(e);
  endtask

  // local bus responder: ready on the rsp_delay-th valid cycle
  initial begin
    int cnt = 0;
    reg_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reg_valid && rst_n) begin
        cnt++;
        reg_ready = rsp_en && (cnt == rsp_delay);
      end else begin
        cnt = 0;
        reg_ready = 1'b0;
      end
    end
  end

  // monitor
  initial begin
    reg_exp_t re;
    rsp_exp_t pe;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (reg_valid) vcyc++;
        if (reg_valid && reg_ready) begin
          racc++;
          if (reg_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL reg_extra: got access %0h expected none",
                     reg_address);
          end else begin
            re = reg_q.pop_front();
            if (re.wr)
              chk("reg_wr", 64'({reg_write, reg_address, reg_wdata,
                  reg_wstrb}), 64'(re));
            else
              chk("reg_rd", 64'({reg_write, reg_address, reg_wstrb}),
                  64'({re.wr, re.addr, re.strb}));
          end
        end
        if (bus.bvalid && bus.bready) begin
          if (rsp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_extra: got bresp %0h expected none",
                     bus.bresp);
          end else begin
            pe = rsp_q.pop_front();
            chk("bresp", 64'({1'b1, bus.bresp}),
                64'({pe.wr, pe.resp}));
          end
        end
        if (bus.rvalid && bus.rready) begin
          if (rsp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_extra: got rdata %0h expected none",
                     bus.rdata);
          end else begin
            pe = rsp_q.pop_front();
            chk("rresp", 64'({1'b0, bus.rresp, bus.rdata}),
                64'(pe));
          end
        end
      end
    end
  end

  task automatic send_aw(input logic [15:0] a);
    int n = 0;
    bus.awaddr = a;
    bus.awvalid = 1'b1;
    do begin @(negedge clk); n++; end
    while (!bus.awready && n < 200);
    if (!bus.awready) tmo("aw_handshake");
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    bus.wdata = d;
    bus.wstrb = s;
    bus.wvalid = 1'b1;
    do begin @(negedge clk); n++; end
    while (!bus.wready && n < 200);
    if (!bus.wready) tmo("w_handshake");
    @(posedge clk);
    #1;
    bus.wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [15:0] a);
    int n = 0;
    bus.araddr = a;
    bus.arvalid = 1'b1;
    do begin @(negedge clk); n++; end
    while (!bus.arready && n < 200);
    if (!bus.arready) tmo("ar_handshake");
    @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((reg_q.size() != 0 || rsp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(reg_q.size() + rsp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int v0;
    int r0;
    int n;
    bus.awvalid = 0; bus.awaddr = '0; bus.awprot = '0;
    bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0;
    bus.arvalid = 0; bus.araddr = '0; bus.arprot = '0;
    bus.bready = 1; bus.rready = 1;
    bus2.awvalid = 0; bus2.awaddr = '0; bus2.awprot = '0;
    bus2.wvalid = 0; bus2.wdata = '0; bus2.wstrb = '0;
    bus2.arvalid = 0; bus2.araddr = '0; bus2.arprot = '0;
    bus2.bready = 1; bus2.rready = 1;
    reg_error = 1'b0;

    #12;
    chk("rst_outputs", 64'({reg_valid, reg_write, reg_address,
        reg_wstrb, bus.bvalid, bus.rvalid}), 64'd0);
    chk("rst_readies", 64'({bus.awready, bus.wready, bus.arready,
        bus2.awready}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'({bus.awready, bus.wready,
        bus.arready}), 64'h7);
    @(posedge clk);
    #1;

    // AW and W together, one-cycle local response
    push_reg(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    push_rsp(1'b1, 2'b00, 32'h0);
    fork
      send_aw(16'h0010);
      send_w(32'hDEADBEEF, 4'hF);
    join
    @(negedge clk);
    chk("t1_idle_gap", 64'(reg_valid), 64'd0);
    @(negedge clk);
    chk("t1_valid_t1", 64'(reg_valid), 64'd1);
    drain();

    // W three cycles ahead of AW
    push_reg(1'b1, 8'h04, 32'h12345678, 4'h3);
    push_rsp(1'b1, 2'b00, 32'h0);
    r0 = racc;
    send_w(32'h12345678, 4'h3);
    repeat (3) begin
      @(negedge clk);
      chk("t2_wready_low", 64'(bus.wready), 64'd0);
    end
    @(posedge clk);
    #1;
    send_aw(16'h0004);
    drain();
    chk("t2_one_write", 64'(racc - r0), 64'd1);
    @(negedge clk);
    chk("t2_wready_back", 64'(bus.wready), 64'd1);
    @(posedge clk);
    #1;

    // local error on a write
    reg_error = 1'b1;
    push_reg(1'b1, 8'h30, 32'hA5A5A5A5, 4'hF);
    push_rsp(1'b1, 2'b10, 32'h0);
    fork
      send_aw(16'h0030);
      send_w(32'hA5A5A5A5, 4'hF);
    join
    drain();
    reg_error = 1'b0;

    // out of range read
    push_rsp(1'b0, 2'b11, 32'h0);
    v0 = vcyc;
    send_ar(16'h0100);
    @(negedge clk);
    chk("t3_rvalid_gap", 64'(bus.rvalid), 64'd0);
    @(negedge clk);
    chk("t3_rvalid_t1", 64'(bus.rvalid), 64'd1);
    drain();
    chk("t3_no_reg_valid", 64'(vcyc - v0), 64'd0);

    // sustained contention, round-robin from write priority
    push_reg(1'b1, 8'h40, 32'h11111111, 4'hF);
    push_reg(1'b0, 8'h44, 32'h0, 4'h0);
    push_reg(1'b1, 8'h48, 32'h22222222, 4'hF);
    push_reg(1'b0, 8'h4C, 32'h0, 4'h0);
    push_rsp(1'b1, 2'b00, 32'h0);
    push_rsp(1'b0, 2'b00, 32'hC0DE0044);
    push_rsp(1'b1, 2'b00, 32'h0);
    push_rsp(1'b0, 2'b00, 32'hC0DE004C);
    fork
      begin
        fork
          send_aw(16'h0040);
          send_w(32'h11111111, 4'hF);
        join
        fork
          send_aw(16'h0048);
          send_w(32'h22222222, 4'hF);
        join
      end
      begin
        send_ar(16'h0044);
        send_ar(16'h004C);
      end
    join
    drain();

    // lone write hands priority to read on next contention
    push_reg(1'b1, 8'h50, 32'h33333333, 4'hF);
    push_rsp(1'b1, 2'b00, 32'h0);
    fork
      send_aw(16'h0050);
      send_w(32'h33333333, 4'hF);
    join
    drain();
    push_reg(1'b0, 8'h58, 32'h0, 4'h0);
    push_reg(1'b1, 8'h54, 32'h44444444, 4'hF);
    push_rsp(1'b0, 2'b00, 32'hC0DE0058);
    push_rsp(1'b1, 2'b00, 32'h0);
    fork
      send_aw(16'h0054);
      send_w(32'h44444444, 4'hF);
      send_ar(16'h0058);
    join
    drain();

    // read-wins instance
    bus2.awaddr = 16'h0060; bus2.awvalid = 1'b1;
    bus2.wdata = 32'h55; bus2.wstrb = 4'hF; bus2.wvalid = 1'b1;
    bus2.araddr = 16'h0064; bus2.arvalid = 1'b1;
    @(negedge clk);
    chk("arb1_readies", 64'({bus2.awready, bus2.wready,
        bus2.arready}), 64'h7);
    @(posedge clk);
    #1;
    bus2.awvalid = 1'b0; bus2.wvalid = 1'b0; bus2.arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!reg_valid_b && n < 50);
    chk("arb1_first", 64'({reg_valid_b, reg_write_b, reg_address_b}),
        64'({1'b1, 1'b0, 8'h64}));
    n = 0;
    do begin @(negedge clk); n++; end
    while (reg_valid_b && n < 50);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!reg_valid_b && n < 50);
    chk("arb1_second", 64'({reg_valid_b, reg_write_b, reg_address_b}),
        64'({1'b1, 1'b1, 8'h60}));
    @(posedge clk);
    #1;

    // watchdog expiry, then ready on the last allowed cycle
    rsp_en = 1'b0;
    push_rsp(1'b0, 2'b10, 32'h0);
    v0 = vcyc;
    send_ar(16'h0020);
    drain();
    chk("t5_timeout_cycles", 64'(vcyc - v0), 64'd8);
    rsp_en = 1'b1;
    rsp_delay = 8;
    push_reg(1'b0, 8'h24, 32'h0, 4'h0);
    push_rsp(1'b0, 2'b00, 32'hC0DE0024);
    v0 = vcyc;
    send_ar(16'h0026);
    drain();
    chk("t5_ready_at_8", 64'(vcyc - v0), 64'd8);
    rsp_delay = 1;

    // reset in the middle of an access
    rsp_en = 1'b0;
    send_ar(16'h0028);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!reg_valid && n < 20);
    chk("t6_in_access", 64'(reg_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_drop", 64'({reg_valid, bus.rvalid, bus.bvalid,
        bus.awready, bus.wready, bus.arready}), 64'd0);
    reg_q.delete();
    rsp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_en = 1'b1;
    push_reg(1'b0, 8'h08, 32'h0, 4'h0);
    push_rsp(1'b0, 2'b00, 32'hC0DE0008);
    send_ar(16'h0008);
    drain();

    chk("final_empty", 64'(reg_q.size() + rsp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
